// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift right / shift left / parallel load while idle,
// plus a serialise burst that loads p_in and right-shifts it out on s_out for len cycles.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic             rot,
  input  logic             s_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] Q,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;

  // Rotation feeds the bit leaving the register back into the vacated end.
  assign w_shr = {(rot ? r_q[0] : s_in), r_q[WIDTH-1:1]};
  assign w_shl = {r_q[WIDTH-2:0], (rot ? r_q[WIDTH-1] : s_in)};

  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_q_next     = p_in;
          w_cnt_next   = len;
          w_state_next = (len != '0) ? S_SHIFT : S_LOAD;
        end else begin
          case (op)
            2'b01:   w_q_next = w_shr;
            2'b10:   w_q_next = w_shl;
            2'b11:   w_q_next = p_in;
            default: w_q_next = r_q;
          endcase
        end
      end
      S_SHIFT: begin
        w_q_next   = w_shr;
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // busy/done are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_LOAD);
    end
  end

  assign Q     = r_q;
  assign s_out = r_q[0];
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ: a cycle-level reference model pushes expectations,
// a negedge monitor pops and compares; directed scenarios add fixed-value checks.
module tb_shift_reg_univ;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    op = 2'b00;
  logic          rot = 1'b0;
  logic          s_in = 1'b0;
  logic [W-1:0]  p_in = '0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic [W-1:0]  Q;
  logic          s_out;
  logic          busy;
  logic          done;

  shift_reg_univ #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .rot(rot), .s_in(s_in), .p_in(p_in),
    .start(start), .len(len), .Q(Q), .s_out(s_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: register value plus the number of busy cycles still to come.
  int m_q    = 0;
  int m_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rsh(input int v, input int b);
    return ((v >> 1) | (b << (W - 1))) & ((1 << W) - 1);
  endfunction

  function automatic int lsh(input int v, input int b);
    return ((v << 1) | b) & ((1 << W) - 1);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_q = 0;
      m_left = 0;
    end else if (m_left > 0) begin
      if (m_left > 1) m_q = rsh(m_q, rot ? (m_q & 1) : int'(s_in));
      m_left--;
    end else if (start) begin
      m_q = int'(p_in);
      m_left = int'(len) + 1;
    end else begin
      case (op)
        2'b01: m_q = rsh(m_q, rot ? (m_q & 1) : int'(s_in));
        2'b10: m_q = lsh(m_q, rot ? ((m_q >> (W - 1)) & 1) : int'(s_in));
        2'b11: m_q = int'(p_in);
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] o, input logic ro, input logic si,
                     input logic st, input logic [W-1:0] p, input logic [CW-1:0] l);
    exp_t e;
    rst = r; op = o; rot = ro; s_in = si; start = st; p_in = p; len = l;
    @(posedge clk);
    model_edge();
    e.q    = m_q[W-1:0];
    e.busy = (m_left > 0);
    e.done = (m_left == 1);
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_Q", Q, e.q);
      chk("sb_s_out", s_out, e.q[0]);
      chk("sb_busy", busy, e.busy);
      chk("sb_done", done, e.done);
    end
  end

  // Burst from p with length l; inj selects a cycle in which start+load are also driven.
  task automatic burst(input logic [W-1:0] p, input logic [CW-1:0] l, input int inj,
                       input logic [W-1:0] qfinal);
    int nb = 0;
    int nd = 0;
    int dat = 0;
    logic [W-1:0] pv;
    pv = p;
    cyc(0, 2'b00, 0, 0, 1, p, l);
    for (int i = 1; i <= int'(l) + 2; i++) begin
      if (i <= int'(l) && i <= W) chk("burst_s_out", s_out, pv[i-1]);
      if (busy) nb++;
      if (done) begin nd++; dat = i; end
      if (i == int'(l) + 1) chk("burst_q_done_cycle", Q, qfinal);
      if (i == inj) cyc(0, 2'b11, 0, 0, 1, 8'hFF, 4'd8);
      else          cyc(0, 2'b00, 0, 0, 0, 8'h00, 4'd0);
    end
    chk("burst_busy_cycles", nb, int'(l) + 1);
    chk("burst_done_count", nd, 1);
    chk("burst_done_cycle", dat, int'(l) + 1);
    chk("burst_busy_after", busy, 1'b0);
    chk("burst_q_after", Q, qfinal);
  endtask

  initial begin
    logic [W-1:0] e27 [3];
    int nd;
    e27 = '{8'hD2, 8'hE9, 8'hF4};

    cyc(1, 2'b00, 0, 0, 0, 8'h00, 4'd0);
    cyc(1, 2'b00, 0, 0, 0, 8'h00, 4'd0);
    chk("reset_Q", Q, 8'h00);
    chk("reset_busy", busy, 1'b0);

    cyc(0, 2'b11, 0, 0, 0, 8'hA5, 4'd0);
    chk("load_A5", Q, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b01, 0, 1, 0, 8'h00, 4'd0);
      chk("shr_s_in", Q, e27[i]);
    end

    cyc(0, 2'b11, 0, 0, 0, 8'h81, 4'd0);
    cyc(0, 2'b10, 1, 0, 0, 8'h00, 4'd0);
    chk("rol_81", Q, 8'h03);
    cyc(0, 2'b01, 1, 0, 0, 8'h00, 4'd0);
    chk("ror_03", Q, 8'h81);
    cyc(0, 2'b01, 1, 0, 0, 8'h00, 4'd0);
    chk("ror_81", Q, 8'hC0);

    burst(8'h3C, 4'd8, 0, 8'h00);
    burst(8'h5A, 4'd0, 0, 8'h5A);
    burst(8'h3C, 4'd8, 3, 8'h00);
    burst(8'h3C, 4'd3, 4, 8'h07);

    cyc(0, 2'b00, 0, 0, 1, 8'h3C, 4'd8);
    repeat (3) cyc(0, 2'b00, 0, 0, 0, 8'h00, 4'd0);
    cyc(1, 2'b00, 0, 0, 0, 8'h00, 4'd0);
    chk("midrst_Q", Q, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 2'b00, 0, 0, 0, 8'h00, 4'd0);
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    burst(8'hC3, 4'd5, 0, 8'h06);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 8'($urandom),
          4'($urandom_range(0, 15)));
    end

    repeat (2) @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
